// File: rtl/demod_seg_pkg.sv
// Shared types and constants for the demodulation segment controller.
// Holds FSM encodings, default parameters and a constant-safe clog2.
package demod_seg_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NUM_SEG = 10;
    localparam int DEF_LATENCY = 3;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/demod_seg_hist.sv
// Per-segment saturating hit histogram with a registered read port
// and a sticky flag raised when any bin first reaches all-ones.
module demod_seg_hist
    import demod_seg_pkg::*;
#(
    parameter int NUM_SEG = DEF_NUM_SEG,
    parameter int CNT_W   = DEF_CNT_W,
    localparam int IDX_W  = clog2(NUM_SEG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [IDX_W-1:0] idx,
    input  logic             clear,
    input  logic [IDX_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             sat
);

    logic [CNT_W-1:0] bins_q [NUM_SEG];
    logic [CNT_W-1:0] bins_d [NUM_SEG];
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             sat_q, sat_d;

    always_comb begin
        bins_d    = bins_q;
        sat_d     = sat_q;
        rd_data_d = '0;
        // Out-of-range selects fall through and read zero.
        for (int i = 0; i < NUM_SEG; i++) begin
            if (int'(rd_sel) == i) rd_data_d = bins_q[i];
        end
        if (clear) begin
            for (int i = 0; i < NUM_SEG; i++) bins_d[i] = '0;
            sat_d = 1'b0;
        end else if (inc) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                if (int'(idx) == i && bins_q[i] != '1) begin
                    bins_d[i] = bins_q[i] + 1'b1;
                    if (bins_d[i] == '1) sat_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bins_q    <= '{default: '0};
            rd_data_q <= '0;
            sat_q     <= 1'b0;
        end else begin
            bins_q    <= bins_d;
            rd_data_q <= rd_data_d;
            sat_q     <= sat_d;
        end
    end

    assign rd_data = rd_data_q;
    assign sat     = sat_q;

endmodule

// File: rtl/demodulation_segment_ctrl_param.sv
// Demodulation segment controller: captures a sample on start, quantises it
// into NUM_SEG equal segments after LATENCY cycles and logs segment hits.
module demodulation_segment_ctrl_param
    import demod_seg_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_SEG = DEF_NUM_SEG,
    parameter int LATENCY = DEF_LATENCY,
    parameter int CNT_W   = DEF_CNT_W,
    localparam int IDX_W  = clog2(NUM_SEG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_hist,
    input  logic [DATA_W-1:0] input_bit,
    output logic              valid,
    output logic              busy,
    output logic [IDX_W-1:0]  seg_idx,
    output logic [NUM_SEG-1:0] seg_onehot,
    input  logic [IDX_W-1:0]  hist_rd_sel,
    output logic [CNT_W-1:0]  hist_rd_data,
    output logic              hist_sat
);

    localparam int PROD_W = DATA_W + clog2(NUM_SEG + 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              start_d_q;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [IDX_W-1:0]  seg_idx_q, seg_idx_d;
    logic [PROD_W-1:0] prod;
    logic [IDX_W-1:0]  idx_c;
    logic              done_entry;

    always_comb begin
        prod  = PROD_W'(sample_q) * PROD_W'(NUM_SEG);
        idx_c = IDX_W'(prod >> DATA_W);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        seg_idx_d  = seg_idx_q;
        done_entry = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !start_d_q) begin
                    state_d  = RUN;
                    cnt_d    = 4'd1;
                    sample_d = input_bit;
                end
            end
            RUN: begin
                if (!start) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (int'(cnt_q) + 1 >= LATENCY) begin
                        state_d    = DONE;
                        seg_idx_d  = idx_c;
                        done_entry = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sample_q  <= '0;
            seg_idx_q <= '0;
            // A start held across reset must not look like a fresh edge.
            start_d_q <= start;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            seg_idx_q <= seg_idx_d;
            start_d_q <= start;
        end
    end

    assign valid      = (state_q == DONE);
    assign busy       = (state_q == RUN);
    assign seg_idx    = seg_idx_q;
    assign seg_onehot = valid ? (NUM_SEG'(1) << seg_idx_q) : '0;

    demod_seg_hist #(
        .NUM_SEG (NUM_SEG),
        .CNT_W   (CNT_W)
    ) u_hist (
        .clk     (clk),
        .reset   (reset),
        .inc     (done_entry),
        .idx     (seg_idx_d),
        .clear   (clear_hist),
        .rd_sel  (hist_rd_sel),
        .rd_data (hist_rd_data),
        .sat     (hist_sat)
    );

endmodule
